// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits split over STAGES register
// slices, 4-bit lookahead groups per slice, valid/ready handshake with full backpressure.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned SLICE  = WIDTH / STAGES;
  localparam int unsigned GROUPS = SLICE / 4;

  // One slice of lookahead addition; returns {carry_out, sum}.
  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             cin);
    logic [SLICE-1:0]  g;
    logic [SLICE-1:0]  p;
    logic [SLICE-1:0]  c;
    logic [GROUPS:0]   gc;
    logic              grp_g;
    logic              grp_p;
    g     = x & y;
    p     = x ^ y;
    c     = '0;
    gc    = '0;
    gc[0] = cin;
    for (int j = 0; j < int'(GROUPS); j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      grp_g    = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      grp_p    = &p[4*j +: 4];
      gc[j+1]  = grp_g | (grp_p & gc[j]);
    end
    return {gc[GROUPS], p ^ c};
  endfunction

  logic [WIDTH-1:0] b_cond;
  logic             cin_cond;
  logic [STAGES:0]  rdy;

  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  st_sum [STAGES];
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_b   [STAGES];
  logic [STAGES-1:0] st_c;
  logic [STAGES-1:0] st_msb_c;

  logic [STAGES-1:0] src_vld;
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [STAGES-1:0] src_c;

  logic [WIDTH-1:0]  nx_sum [STAGES];
  logic [STAGES-1:0] nx_c;
  logic [STAGES-1:0] nx_msb_c;

  // Subtraction is a + ~b + !borrow.
  always_comb begin : operand_cond
    b_cond   = sub ? ~b : b;
    cin_cond = carry_in ^ sub;
  end

  // Backpressure chain from the consumer towards the producer.
  always_comb begin : ready_chain
    logic r;
    rdy         = '0;
    r           = out_ready;
    rdy[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      r      = ~vld[k] | r;
      rdy[k] = r;
    end
  end

  // Stage inputs: stage 0 sees the conditioned operands, stage k sees register k-1.
  always_comb begin : stage_sources
    src_vld[0] = in_valid;
    src_sum[0] = '0;
    src_a[0]   = a;
    src_b[0]   = b_cond;
    src_c[0]   = cin_cond;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_vld[k] = vld[k-1];
      src_sum[k] = st_sum[k-1];
      src_a[k]   = st_a[k-1];
      src_b[k]   = st_b[k-1];
      src_c[k]   = st_c[k-1];
    end
  end

  always_comb begin : slice_datapath
    logic [SLICE:0] res;
    res      = '0;
    nx_c     = '0;
    nx_msb_c = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      res       = cla_slice(src_a[k][k*SLICE +: SLICE], src_b[k][k*SLICE +: SLICE], src_c[k]);
      nx_sum[k] = src_sum[k];
      nx_sum[k][k*SLICE +: SLICE] = res[SLICE-1:0];
      nx_c[k]   = res[SLICE];
      // Carry into the MSB is only known once the top slice has been added.
      if (k == int'(STAGES) - 1)
        nx_msb_c[k] = src_a[k][WIDTH-1] ^ src_b[k][WIDTH-1] ^ res[SLICE-1];
    end
  end

  always_ff @(posedge clk) begin : stage_regs
    if (rst) begin
      vld      <= '0;
      st_c     <= '0;
      st_msb_c <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        st_sum[k] <= '0;
        st_a[k]   <= '0;
        st_b[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (rdy[k]) begin
          vld[k]      <= src_vld[k];
          st_sum[k]   <= nx_sum[k];
          st_a[k]     <= src_a[k];
          st_b[k]     <= src_b[k];
          st_c[k]     <= nx_c[k];
          st_msb_c[k] <= nx_msb_c[k];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES-1];
  assign sum       = st_sum[STAGES-1];
  assign carry_out = st_c[STAGES-1];
  assign overflow  = st_msb_c[STAGES-1] ^ st_c[STAGES-1];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench: a 16-bit/2-stage DUT for directed, backpressure and reset tests,
// plus 32-bit DUTs at STAGES=1,2,4,8 fed a shared random stream.
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic [31:0] acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        carry_in, sub, carry_out, overflow;

  logic        sw_valid, sw_ordy, sw_cin, sw_sub;
  logic [31:0] sw_a, sw_b;

  logic [31:0] cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_acc = 0;
  logic        lat_en, drain_chk;
  exp_t        m_q[$];
  logic        m_seen;
  exp_t        m_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global timeout: cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  pipelined_cla_adder #(.WIDTH(16), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Arithmetic reference in wide signed/unsigned integers.
  function automatic exp_t model(input int unsigned w, input logic [31:0] x, input logic [31:0] y,
                                 input logic cin, input logic sub_v, input logic [31:0] acc);
    longint pw, ua, ub, sa, sb, ru, rs;
    exp_t   e;
    pw = longint'(1) << w;
    ua = longint'(x) & (pw - 1);
    ub = longint'(y) & (pw - 1);
    sa = (ua >= pw / 2) ? ua - pw : ua;
    sb = (ub >= pw / 2) ? ub - pw : ub;
    if (sub_v) begin
      ru     = ua - ub - longint'(cin);
      rs     = sa - sb - longint'(cin);
      e.cout = (ua >= ub + longint'(cin));
    end else begin
      ru     = ua + ub + longint'(cin);
      rs     = sa + sb + longint'(cin);
      e.cout = (ru >= pw);
    end
    e.sum = 32'(ru & (pw - 1));
    e.ovf = (rs < -(pw / 2)) || (rs >= pw / 2);
    e.acc = acc;
    return e;
  endfunction

  // Main DUT scoreboard: push at accept, compare head while valid, pop at transfer.
  always @(negedge clk) begin
    if (rst) begin
      m_q.delete();
      m_seen = 1'b0;
    end else begin
      if (out_valid) begin
        if (m_q.size() == 0) check("spurious out_valid", 1, 0);
        else begin
          m_e = m_q[0];
          check("sum", longint'(sum), longint'(m_e.sum));
          check("carry_out", longint'(carry_out), longint'(m_e.cout));
          check("overflow", longint'(overflow), longint'(m_e.ovf));
          if (lat_en && !m_seen) check("latency", longint'(cyc - m_e.acc + 1), 2);
          m_seen = 1'b1;
          if (out_ready) begin
            void'(m_q.pop_front());
            m_seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        m_q.push_back(model(16, {16'h0, a}, {16'h0, b}, carry_in, sub, cyc + 1));
        n_acc++;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int unsigned S = 1 << g;
    logic        ir, ov, co, of;
    logic [31:0] sm;
    exp_t        q[$];
    exp_t        e;

    pipelined_cla_adder #(.WIDTH(32), .STAGES(S)) u_sw (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(ir),
      .a(sw_a), .b(sw_b), .carry_in(sw_cin), .sub(sw_sub),
      .out_valid(ov), .out_ready(sw_ordy),
      .sum(sm), .carry_out(co), .overflow(of)
    );

    always @(negedge clk) begin
      if (rst) q.delete();
      else begin
        if (ov) begin
          if (q.size() == 0) check($sformatf("s%0d spurious out_valid", S), 1, 0);
          else begin
            e = q.pop_front();
            check($sformatf("s%0d sum", S), longint'(sm), longint'(e.sum));
            check($sformatf("s%0d carry_out", S), longint'(co), longint'(e.cout));
            check($sformatf("s%0d overflow", S), longint'(of), longint'(e.ovf));
            check($sformatf("s%0d latency", S), longint'(cyc - e.acc + 1), longint'(S));
          end
        end
        if (sw_valid && ir) q.push_back(model(32, sw_a, sw_b, sw_cin, sw_sub, cyc + 1));
        if (drain_chk) check($sformatf("s%0d drain", S), longint'(q.size()), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted.
  task automatic drive(input logic [15:0] a_v, input logic [15:0] b_v,
                       input logic cin_v, input logic sub_v);
    logic took;
    int   t;
    t        = 0;
    in_valid = 1'b1;
    a        = a_v;
    b        = b_v;
    carry_in = cin_v;
    sub      = sub_v;
    forever begin
      @(negedge clk);
      took = in_ready;
      tick();
      if (took) break;
      t++;
      if (t > 500) begin
        check("accept timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  logic prod_done;
  int   base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    out_ready = 1'b1; sw_valid = 1'b0; sw_ordy = 1'b1; sw_a = '0; sw_b = '0;
    sw_cin = 1'b0; sw_sub = 1'b0; lat_en = 1'b0; drain_chk = 1'b0; prod_done = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset sum", longint'(sum), 0);
    check("reset carry_out", longint'(carry_out), 0);
    check("reset overflow", longint'(overflow), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset", longint'(in_ready), 1);
    tick();

    // Back-to-back adds, boundaries, subtracts with latency checking.
    lat_en = 1'b1;
    drive(16'd10, 16'd22, 1'b0, 1'b0);
    drive(16'd120, 16'd82, 1'b0, 1'b0);
    drive(16'd928, 16'd910, 1'b1, 1'b0);
    drive(16'd7, 16'd1, 1'b1, 1'b0);
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drive(16'h8000, 16'h8000, 1'b0, 1'b0);
    drive(16'd7, 16'd1, 1'b0, 1'b1);
    drive(16'd1, 16'd7, 1'b0, 1'b1);
    drive(16'd100, 16'd40, 1'b1, 1'b1);
    drive(16'h8000, 16'h0001, 1'b0, 1'b1);
    repeat (6) tick();
    lat_en = 1'b0;
    check("directed drain", longint'(m_q.size()), 0);

    // Full stall: only STAGES beats enter, then everything drains in order.
    out_ready = 1'b0;
    base = n_acc;
    fork
      for (int i = 0; i < 6; i++) drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      begin
        repeat (8) tick();
        @(negedge clk);
        check("in_ready stalled", longint'(in_ready), 0);
        check("accepted while stalled", longint'(n_acc - base), 2);
        check("out_valid stalled", longint'(out_valid), 1);
        tick();
        out_ready = 1'b1;
      end
    join
    repeat (6) tick();
    check("stall drain", longint'(m_q.size()), 0);

    // Random valid/ready sweep.
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(3) == 0) tick();
          drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          out_ready = 1'($urandom);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    repeat (6) tick();
    check("random drain", longint'(m_q.size()), 0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    drive(16'd1111, 16'd2222, 1'b0, 1'b0);
    drive(16'd3333, 16'd4444, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("mid reset out_valid", longint'(out_valid), 0);
    check("mid reset sum", longint'(sum), 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no stale out_valid", longint'(out_valid), 0);
      tick();
    end
    lat_en = 1'b1;
    drive(16'h1234, 16'h4321, 1'b1, 1'b0);
    repeat (5) tick();
    lat_en = 1'b0;
    check("post reset drain", longint'(m_q.size()), 0);

    // 32-bit stream into all STAGES variants.
    for (int i = 0; i < 1000; i++) begin
      sw_valid = 1'b1;
      sw_a     = $urandom;
      sw_b     = $urandom;
      sw_cin   = 1'($urandom);
      sw_sub   = 1'($urandom);
      if (i % 50 == 0) begin
        sw_a = 32'hFFFF_FFFF;
        sw_b = 32'h0000_0001;
      end
      tick();
    end
    sw_valid = 1'b0;
    repeat (12) tick();
    drain_chk = 1'b1;
    tick();
    drain_chk = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor and the successor to the fixed 16-bit combinational CLA adder. Splits a WIDTH-bit add across STAGES register slices. Each slice uses 4-bit lookahead groups, and carry is registered between slices. A valid/ready handshake on both sides gives one result per cycle with full backpressure. Sits between operand producers and accumulator/datapath consumers in the arithmetic cluster.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES*4.
STAGES, 2, number of pipeline register slices (1..8); each slice resolves SLICE = WIDTH/STAGES bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A (unsigned or two's complement)
b  input  WIDTH  operand B
carry_in  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: a+b+carry_in; 1: a-b-carry_in
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result this cycle
sum  output  WIDTH  result
carry_out  output  1  carry out of MSB (sub: 1 = no borrow)
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset: on any clk edge with rst=1, all stage valid bits clear. out_valid=0, sum=0, carry_out=0, overflow=0. in_ready=1 in the cycle after reset deasserts. In-flight beats are discarded, with no partial output.
- Operand conditioning at accept:
  - sub=0: B' = b, cin' = carry_in.
  - sub=1: B' = ~b, cin' = ~carry_in, i.e. a + ~b + !borrow.
- Slice k (0..STAGES-1) adds bits [k*SLICE +: SLICE] of a and B' with the carry registered from slice k-1; slice 0 uses cin'.
  - Within a slice, 4-bit groups form generate/propagate terms. Group carries come from a lookahead chain, not a ripple through bits.
- Stage register k holds:
  - valid_k
  - the low (k+1)*SLICE sum bits
  - the carry out of slice k
  - the carry into bit WIDTH-1, once resolved
  - the unprocessed upper bits of a and B', skewed forward
- The final stage register drives sum/carry_out/overflow directly; there is no combinational path from a/b to the outputs.
- Handshake:
  - Accept happens when in_valid & in_ready at an edge; transfer happens when out_valid & out_ready.
  - ready_k = !valid_k | ready_{k+1}; ready_STAGES = out_ready; in_ready = ready_0.
  - in_ready depends combinationally on out_ready; there is no skid buffer.
  - Stage k loads from stage k-1 when ready_k. Its valid_k becomes valid_{k-1}, with in_valid used for k=0.
- Latency: a beat accepted at edge N is presented with out_valid=1 in the cycle after edge N+STAGES-1 when unstalled. Throughput is 1 beat/cycle.
- Stall: while out_valid=1 and out_ready=0, sum/carry_out/overflow/out_valid hold stable. Stages fill until in_ready=0, and no beat is dropped or duplicated.
- Bubbles: invalid stages may take any data. Accept and transfer in the same cycle are legal at every stage when full.
- in_valid with in_ready=0: the inputs are ignored. The producer must hold them, but the block must not rely on this.
- Arithmetic is modulo 2^WIDTH. carry_out and overflow are computed over the full WIDTH regardless of STAGES.
- Results must be bit-identical for every legal STAGES value with the same WIDTH.

Test Plan:
1. WIDTH=16, STAGES=2, out_ready=1: back-to-back beats (10,22,0,add), (120,82,0,add), (928,910,1,add), (7,1,1,add) -> sums 32, 202, 1839, 9 on four consecutive cycles, first out_valid 2 cycles after first accept, carry_out=0, overflow=0.
2. Boundary: (0xFFFF,0x0001,0,add) -> sum 0x0000, carry_out=1, overflow=0; (0x7FFF,0x0001,0,add) -> sum 0x8000, carry_out=0, overflow=1; (0x8000,0x8000,0,add) -> 0x0000, carry_out=1, overflow=1.
3. Subtract: (7,1,0,sub) -> 6, carry_out=1; (1,7,0,sub) -> 0xFFFA, carry_out=0; (100,40,1,sub) -> 59, carry_out=1; (0x8000,0x0001,0,sub) -> 0x7FFF, overflow=1.
4. Backpressure: stream 6 beats with out_ready=0 -> in_ready drops after STAGES accepts and out_valid/sum hold stable. Then out_ready=1 -> all 6 results in order, none lost or duplicated. A random in_valid/out_ready sweep matches the reference model.
5. Reset mid-operation: rst=1 for one edge with 2 beats in flight -> out_valid=0 and sum=0 next cycle. No stale result appears afterward, and the next accepted beat has correct latency.
6. Parameter sweep: WIDTH=32 with STAGES=1,2,4,8 on 1000 random operands -> outputs match a golden (a±b±cin) model; latency equals STAGES.
